// File: rtl/ifetch_stage_pkg.sv
// Shared constants, state encoding and output-buffer payload for the instruction-fetch stage.
package ifetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] BUBBLE_INSTR      = 32'h0000_003F;
    localparam logic [XLEN-1:0] END_INSTR_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] PC_STEP           = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } fetch_buf_t;

    // Sequential word address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return XLEN'(pc + PC_STEP);
    endfunction

endpackage

// File: rtl/ifetch_perf_counters.sv
// Saturating fetch and bubble event counters for the instruction-fetch stage.
module ifetch_perf_counters
    import ifetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_inc,
    input  logic            bubble_inc,
    output logic [XLEN-1:0] fetch_cnt,
    output logic [XLEN-1:0] bubble_cnt
);

    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fetch_inc && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = XLEN'(fetch_cnt_q + XLEN'(1));
        end
        if (bubble_inc && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = XLEN'(bubble_cnt_q + XLEN'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC owner with a single-outstanding imem handshake feeding IF/ID.
// Optional IFETCH_PERF_EN adds saturating fetch/bubble performance counters.
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] END_INSTR = END_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_rready,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            ValidF,
    output logic            HaltF
`ifdef IFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_bubble_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    fetch_buf_t      obuf_q, obuf_d;

    logic accept_c;
    logic end_hit_c;
    logic req_hs_c;
    logic rsp_live_c;

    // Memory handshake: rready frees the buffer slot, a new request may chain on an accept.
    always_comb begin
        imem_rready = drop_q | ~obuf_q.valid | ~stallF;
        accept_c    = imem_rvalid & imem_rready;
        end_hit_c   = (imem_rdata == END_INSTR);
        rsp_live_c  = accept_c & (state_q == S_WAIT);
        imem_req    = rst & ~redirect &
                      ((state_q == S_REQ) |
                       ((state_q == S_WAIT) & accept_c & ~drop_q & ~end_hit_c));
        req_hs_c    = imem_req & imem_ack;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        obuf_d   = obuf_q;

        if (obuf_q.valid && !stallF) begin
            obuf_d.valid = 1'b0;
            obuf_d.instr = BUBBLE_INSTR;
        end

        if (req_hs_c) begin
            req_pc_d = pc_q;
            pc_d     = pc_incr(pc_q);
            state_d  = S_WAIT;
        end

        if (rsp_live_c) begin
            if (drop_q) begin
                drop_d  = 1'b0;
                state_d = S_REQ;
            end else begin
                obuf_d = '{instr: imem_rdata, pcplus4: pc_incr(req_pc_q), valid: 1'b1};
                if (end_hit_c) begin
                    state_d = S_HALT;
                end else if (!req_hs_c) begin
                    state_d = S_REQ;
                end
            end
        end

        // Redirect wins over everything; an in-flight response is marked for discard.
        if (redirect) begin
            pc_d           = redirect_pc;
            obuf_d.valid   = 1'b0;
            obuf_d.instr   = BUBBLE_INSTR;
            obuf_d.pcplus4 = obuf_q.pcplus4;
            if ((state_q == S_WAIT) && !accept_c) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            obuf_q   <= '{instr: BUBBLE_INSTR, pcplus4: '0, valid: 1'b0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            obuf_q   <= obuf_d;
        end
    end

    assign imem_addr = pc_q;
    assign InstrF    = obuf_q.instr;
    assign PCPlus4F  = obuf_q.pcplus4;
    assign ValidF    = obuf_q.valid;
    assign HaltF     = (state_q == S_HALT);

`ifdef IFETCH_PERF_EN
    logic fetch_inc_c;
    logic bubble_inc_c;

    assign fetch_inc_c  = rsp_live_c & ~drop_q & ~redirect;
    assign bubble_inc_c = ~obuf_q.valid & (state_q != S_HALT);

    ifetch_perf_counters u_perf (
        .clk        (clk),
        .rst        (rst),
        .fetch_inc  (fetch_inc_c),
        .bubble_inc (bubble_inc_c),
        .fetch_cnt  (perf_fetch_cnt),
        .bubble_cnt (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a single-outstanding memory model (addr returned as data).
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallF = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rready;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        HaltF;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    ifetch_stage #(
        .RESET_PC  (32'h0000_0100),
        .END_INSTR (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_rready (imem_rready),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .ValidF      (ValidF),
        .HaltF       (HaltF)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    // Memory: one response per accepted request, after mem_wait idle cycles, held until rready.
    logic        mem_pend;
    logic [31:0] mem_addr_q;
    int unsigned mem_cnt;
    int unsigned mem_wait = 0;
    logic [31:0] end_addr = 32'hDEAD_0000;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_pend   <= 1'b0;
            mem_addr_q <= 32'h0;
            mem_cnt    <= 0;
        end else if (imem_req && imem_ack) begin
            mem_pend   <= 1'b1;
            mem_addr_q <= imem_addr;
            mem_cnt    <= mem_wait;
        end else if (imem_rvalid && imem_rready) begin
            mem_pend <= 1'b0;
        end else if (mem_pend && mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    assign imem_rvalid = mem_pend && (mem_cnt == 0);
    assign imem_rdata  = (mem_addr_q == end_addr) ? 32'hFFFF_FFFF : mem_addr_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, then the caller samples.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rp, input logic a);
        @(negedge clk);
        stallF      = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ack    = a;
        #1;
    endtask

    task automatic do_reset(input int unsigned w, input logic [31:0] ea);
        @(negedge clk);
        rst         = 1'b0;
        stallF      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b1;
        mem_wait    = w;
        end_addr    = ea;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        req;
        logic [31:0] addr;
        logic        rready;
        logic        halt;
    } vec_t;

    vec_t va[10];

    initial begin
        // Zero-wait stream from 0x100 with a 4-cycle stall while the buffer is full.
        va[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3F,  32'h0,   1'b1, 32'h100, 1'b1, 1'b0};
        va[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3F,  32'h0,   1'b1, 32'h104, 1'b1, 1'b0};
        va[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h104, 1'b1, 32'h108, 1'b1, 1'b0};
        va[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h108, 1'b0, 32'h10C, 1'b0, 1'b0};
        va[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h108, 1'b0, 32'h10C, 1'b0, 1'b0};
        va[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h108, 1'b0, 32'h10C, 1'b0, 1'b0};
        va[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h108, 1'b0, 32'h10C, 1'b0, 1'b0};
        va[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h108, 1'b1, 32'h10C, 1'b1, 1'b0};
        va[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 32'h10C, 1'b1, 32'h110, 1'b1, 1'b0};
        va[9] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10C, 32'h110, 1'b1, 32'h114, 1'b1, 1'b0};

        // Reset values while rst is held low.
        #6;
        chk("rst req",    32'(imem_req), 32'h0);
        chk("rst valid",  32'(ValidF),   32'h0);
        chk("rst instr",  InstrF,        32'h3F);
        chk("rst pcp4",   PCPlus4F,      32'h0);
        chk("rst halt",   32'(HaltF),    32'h0);
        chk("rst addr",   imem_addr,     32'h100);

        do_reset(0, 32'hDEAD_0000);
        for (int i = 0; i < 10; i++) begin
            cyc(va[i].stall, va[i].redir, va[i].rpc, va[i].ack);
            chk($sformatf("A%0d valid", i),  32'(ValidF),      32'(va[i].valid));
            chk($sformatf("A%0d instr", i),  InstrF,           va[i].instr);
            chk($sformatf("A%0d pcp4", i),   PCPlus4F,         va[i].pcp4);
            chk($sformatf("A%0d req", i),    32'(imem_req),    32'(va[i].req));
            chk($sformatf("A%0d addr", i),   imem_addr,        va[i].addr);
            chk($sformatf("A%0d rready", i), 32'(imem_rready), 32'(va[i].rready));
            chk($sformatf("A%0d halt", i),   32'(HaltF),       32'(va[i].halt));
        end

        // Three wait cycles per response: bubbles until each instruction arrives.
        do_reset(3, 32'hDEAD_0000);
        cyc(0, 0, 0, 1);
        chk("B0 addr", imem_addr, 32'h100);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 1);
            chk($sformatf("B%0d valid", i), 32'(ValidF), 32'h0);
            chk($sformatf("B%0d instr", i), InstrF,      32'h3F);
        end
        cyc(0, 0, 0, 1);
        chk("B4 req",  32'(imem_req), 32'h1);
        chk("B4 addr", imem_addr,     32'h104);
        cyc(0, 0, 0, 1);
        chk("B5 valid", 32'(ValidF), 32'h1);
        chk("B5 instr", InstrF,      32'h100);
        chk("B5 pcp4",  PCPlus4F,    32'h104);
        chk("B5 req",   32'(imem_req), 32'h0);
        cyc(0, 0, 0, 1);
        chk("B6 valid", 32'(ValidF), 32'h0);
        chk("B6 instr", InstrF,      32'h3F);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("B9 instr", InstrF,   32'h104);
        chk("B9 pcp4",  PCPlus4F, 32'h108);

        // Redirect to 0x200 while the 0x104 response is still outstanding.
        do_reset(2, 32'hDEAD_0000);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h200, 1);
        chk("C4 instr", InstrF,        32'h100);
        chk("C4 req",   32'(imem_req), 32'h0);
        cyc(0, 0, 0, 1);
        chk("C5 valid", 32'(ValidF),   32'h0);
        chk("C5 req",   32'(imem_req), 32'h0);
        chk("C5 addr",  imem_addr,     32'h200);
        cyc(0, 0, 0, 1);
        chk("C6 rready", 32'(imem_rready), 32'h1);
        chk("C6 req",    32'(imem_req),    32'h0);
        for (int i = 7; i <= 10; i++) begin
            cyc(0, 0, 0, 1);
            chk($sformatf("C%0d valid", i), 32'(ValidF), 32'h0);
            if (i == 7) begin
                chk("C7 req",  32'(imem_req), 32'h1);
                chk("C7 addr", imem_addr,     32'h200);
            end
        end
        cyc(0, 0, 0, 1);
        chk("C11 instr", InstrF,      32'h200);
        chk("C11 pcp4",  PCPlus4F,    32'h204);
        chk("C11 valid", 32'(ValidF), 32'h1);

        // END_INSTR at 0x10C halts fetch; redirect to 0x40 resumes.
        do_reset(0, 32'h10C);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("D4 req",  32'(imem_req), 32'h0);
        chk("D4 halt", 32'(HaltF),    32'h0);
        cyc(0, 0, 0, 1);
        chk("D5 instr", InstrF,        32'hFFFF_FFFF);
        chk("D5 pcp4",  PCPlus4F,      32'h110);
        chk("D5 valid", 32'(ValidF),   32'h1);
        chk("D5 halt",  32'(HaltF),    32'h1);
        chk("D5 req",   32'(imem_req), 32'h0);
        cyc(0, 0, 0, 1);
        chk("D6 valid", 32'(ValidF),   32'h0);
        chk("D6 halt",  32'(HaltF),    32'h1);
        chk("D6 req",   32'(imem_req), 32'h0);
        cyc(0, 1, 32'h40, 1);
        chk("D7 req",  32'(imem_req), 32'h0);
        cyc(0, 0, 0, 1);
        chk("D8 halt", 32'(HaltF),    32'h0);
        chk("D8 req",  32'(imem_req), 32'h1);
        chk("D8 addr", imem_addr,     32'h40);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("D10 instr", InstrF,   32'h40);
        chk("D10 pcp4",  PCPlus4F, 32'h44);

        // Ten fetches with one missed ack: three bubble cycles in total.
        do_reset(0, 32'hDEAD_0000);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("E6 instr", InstrF,        32'h110);
        chk("E6 req",   32'(imem_req), 32'h1);
        chk("E6 addr",  imem_addr,     32'h114);
        cyc(0, 0, 0, 1);
        chk("E7 valid", 32'(ValidF), 32'h0);
        for (int i = 8; i <= 12; i++) cyc(0, 0, 0, 1);
        chk("E12 instr", InstrF,   32'h124);
        chk("E12 pcp4",  PCPlus4F, 32'h128);
`ifdef IFETCH_PERF_EN
        chk("E12 perf_fetch",  perf_fetch_cnt,  32'd10);
        chk("E12 perf_bubble", perf_bubble_cnt, 32'd3);
`endif

        // Asynchronous reset mid-stream returns everything to the reset state.
        #1 rst = 1'b0;
        #1;
        chk("ar valid", 32'(ValidF), 32'h0);
        chk("ar instr", InstrF,      32'h3F);
        chk("ar addr",  imem_addr,   32'h100);
        chk("ar req",   32'(imem_req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
